cbfp1_scale_apply: RTL and testbench

- Consumer side of the stage-1 CBFP min-detect path.
- Holds each beat of butterfly add/sub outputs (8 complex add + 8 complex sub samples per beat) in a delay line until the matching common leading-sign count (min_add / min_sub) arrives from the min detector.
- Normalises every sample by that count with round-to-nearest and saturation to OUT_WIDTH.
- Emits the scaled samples, the applied exponent per group, and frame-boundary flags to the next FFT stage.

---
 rtl/cbfp1_scale_apply.sv | 142 ++++++++++++++
 tb/tb_cbfp1_scale_apply.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp1_scale_apply.sv
// Stage-1 CBFP scale apply: delays butterfly beats until their
// common leading-sign count arrives, then normalises and saturates.
module cbfp1_scale_apply #(
    parameter int IN_WIDTH    = 23,
    parameter int OUT_WIDTH   = 11,
    parameter int LZC_WIDTH   = 5,
    parameter int MIN_LAT     = 2,
    parameter int FRAME_BEATS = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  din_R_add [0:7],
    input  logic [IN_WIDTH-1:0]  din_Q_add [0:7],
    input  logic [IN_WIDTH-1:0]  din_R_sub [0:7],
    input  logic [IN_WIDTH-1:0]  din_Q_sub [0:7],
    input  logic [LZC_WIDTH-1:0] min_add,
    input  logic [LZC_WIDTH-1:0] min_sub,
    output logic [OUT_WIDTH-1:0] dout_R_add [0:7],
    output logic [OUT_WIDTH-1:0] dout_Q_add [0:7],
    output logic [OUT_WIDTH-1:0] dout_R_sub [0:7],
    output logic [OUT_WIDTH-1:0] dout_Q_sub [0:7],
    output logic [LZC_WIDTH-1:0] exp_add,
    output logic [LZC_WIDTH-1:0] exp_sub,
    output logic                 out_valid,
    output logic                 out_last
);

    localparam int NS = 32;
    localparam int D  = IN_WIDTH - OUT_WIDTH;
    localparam int WW = 2 * IN_WIDTH - 1;
    localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    localparam logic signed [WW-1:0] RND    = WW'(2 ** (D - 1));
    localparam logic signed [WW-1:0] SAT_HI = WW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [WW-1:0] SAT_LO = ~SAT_HI;

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BEATS - 1);
    localparam logic [LZC_WIDTH-1:0] S_MAX = LZC_WIDTH'(IN_WIDTH - 1);

    logic [IN_WIDTH-1:0]  din_all [0:NS-1];
    logic [IN_WIDTH-1:0]  dl_data [0:MIN_LAT-1][0:NS-1];
    logic [MIN_LAT-1:0]   dl_vld;
    logic                 tail_v;
    logic [LZC_WIDTH-1:0] s_add;
    logic [LZC_WIDTH-1:0] s_sub;
    logic [OUT_WIDTH-1:0] sc [0:NS-1];
    logic [CW-1:0]        cnt;

    // Shift, round half up, then clamp into the output range.
    function automatic logic [OUT_WIDTH-1:0] scale(
        input logic [IN_WIDTH-1:0]  x,
        input logic [LZC_WIDTH-1:0] s
    );
        logic signed [WW-1:0] w;
        logic signed [WW-1:0] r;
        w = {{(WW - IN_WIDTH){x[IN_WIDTH-1]}}, x};
        w = w <<< s;
        r = (w + RND) >>> D;
        if (r > SAT_HI)
            return SAT_HI[OUT_WIDTH-1:0];
        else if (r < SAT_LO)
            return SAT_LO[OUT_WIDTH-1:0];
        else
            return r[OUT_WIDTH-1:0];
    endfunction

    // Flatten the four input lanes into one sample vector.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            din_all[i]      = din_R_add[i];
            din_all[8 + i]  = din_Q_add[i];
            din_all[16 + i] = din_R_sub[i];
            din_all[24 + i] = din_Q_sub[i];
        end
    end

    // Delay line: shifts every cycle so the tail meets its min count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_vld <= '0;
            for (int k = 0; k < MIN_LAT; k++)
                for (int i = 0; i < NS; i++)
                    dl_data[k][i] <= '0;
        end else begin
            dl_vld[0]  <= in_valid;
            dl_data[0] <= din_all;
            for (int k = 1; k < MIN_LAT; k++) begin
                dl_vld[k]  <= dl_vld[k-1];
                dl_data[k] <= dl_data[k-1];
            end
        end
    end

    assign tail_v = dl_vld[MIN_LAT-1];

    // Clamp shift counts to the largest meaningful shift.
    always_comb begin
        s_add = (int'(min_add) > IN_WIDTH - 1) ? S_MAX : min_add;
        s_sub = (int'(min_sub) > IN_WIDTH - 1) ? S_MAX : min_sub;
    end

    // Normalise all tail samples with their group's shift.
    always_comb begin
        for (int i = 0; i < NS; i++)
            sc[i] = scale(dl_data[MIN_LAT-1][i], (i < 16) ? s_add : s_sub);
    end

    // Output register with frame beat counter; holds data when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                dout_R_add[i] <= '0;
                dout_Q_add[i] <= '0;
                dout_R_sub[i] <= '0;
                dout_Q_sub[i] <= '0;
            end
            exp_add   <= '0;
            exp_sub   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt       <= '0;
        end else begin
            out_valid <= tail_v;
            if (tail_v) begin
                for (int i = 0; i < 8; i++) begin
                    dout_R_add[i] <= sc[i];
                    dout_Q_add[i] <= sc[8 + i];
                    dout_R_sub[i] <= sc[16 + i];
                    dout_Q_sub[i] <= sc[24 + i];
                end
                exp_add  <= s_add;
                exp_sub  <= s_sub;
                out_last <= (cnt == CNT_LAST);
                cnt      <= cnt + CW'(1);
            end else begin
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cbfp1_scale_apply.sv
// Bench for cbfp1_scale_apply: directed and random beats checked
// against an arithmetic reference of the normalisation rules.
module tb_cbfp1_scale_apply;

    localparam int IW = 23;
    localparam int OW = 11;
    localparam int LW = 5;
    localparam int ML = 2;
    localparam int FB = 64;
    localparam int PMAX = 128;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [IW-1:0] din_R_add [0:7];
    logic [IW-1:0] din_Q_add [0:7];
    logic [IW-1:0] din_R_sub [0:7];
    logic [IW-1:0] din_Q_sub [0:7];
    logic [LW-1:0] min_add;
    logic [LW-1:0] min_sub;
    logic [OW-1:0] dout_R_add [0:7];
    logic [OW-1:0] dout_Q_add [0:7];
    logic [OW-1:0] dout_R_sub [0:7];
    logic [OW-1:0] dout_Q_sub [0:7];
    logic [LW-1:0] exp_add;
    logic [LW-1:0] exp_sub;
    logic          out_valid;
    logic          out_last;

    int checks = 0;
    int failures = 0;

    bit pv [0:PMAX-1];
    int px [0:PMAX-1][0:31];
    int pma [0:PMAX-1];
    int pms [0:PMAX-1];
    int plen;
    int cyc;

    bit e_v;
    bit e_l;
    int e_d [0:31];
    int e_ea;
    int e_es;
    int m_cnt;

    cbfp1_scale_apply #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .LZC_WIDTH(LW),
        .MIN_LAT(ML), .FRAME_BEATS(FB)
    ) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid),
        .din_R_add(din_R_add), .din_Q_add(din_Q_add),
        .din_R_sub(din_R_sub), .din_Q_sub(din_Q_sub),
        .min_add(min_add), .min_sub(min_sub),
        .dout_R_add(dout_R_add), .dout_Q_add(dout_Q_add),
        .dout_R_sub(dout_R_sub), .dout_Q_sub(dout_Q_sub),
        .exp_add(exp_add), .exp_sub(exp_sub),
        .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int rnd_x();
        int r;
        r = int'($urandom);
        return r >>> $urandom_range(9, 31);
    endfunction

    function automatic int clamp_s(int m);
        return (m > IW - 1) ? IW - 1 : m;
    endfunction

    // x * 2^s, add half an output LSB, floor-divide, saturate.
    function automatic int ref_scale(int x, int m);
        longint w;
        longint r;
        w = longint'(x) * (longint'(1) << clamp_s(m));
        r = (w + (longint'(1) << (IW - OW - 1))) >>> (IW - OW);
        if (r > 1023) r = 1023;
        if (r < -1024) r = -1024;
        return int'(r);
    endfunction

    function automatic int got(int j);
        logic [OW-1:0] v;
        case (j / 8)
            0: v = dout_R_add[j % 8];
            1: v = dout_Q_add[j % 8];
            2: v = dout_R_sub[j % 8];
            default: v = dout_Q_sub[j % 8];
        endcase
        return int'($signed(v));
    endfunction

    task automatic set_din(int j, int val);
        logic [IW-1:0] v;
        v = IW'(val);
        case (j / 8)
            0: din_R_add[j % 8] = v;
            1: din_Q_add[j % 8] = v;
            2: din_R_sub[j % 8] = v;
            default: din_Q_sub[j % 8] = v;
        endcase
    endtask

    task automatic model_reset();
        m_cnt = 0;
        e_v = 0;
        e_l = 0;
        e_ea = 0;
        e_es = 0;
        for (int j = 0; j < 32; j++) e_d[j] = 0;
    endtask

    task automatic clear_plan();
        plen = 0;
        cyc = 0;
    endtask

    task automatic add_beat(bit v, int ma, int ms, int xa, int xs, bit rnd);
        pv[plen] = v;
        pma[plen] = ma;
        pms[plen] = ms;
        for (int j = 0; j < 32; j++)
            px[plen][j] = rnd ? rnd_x() : ((j < 16) ? xa : xs);
        plen++;
    endtask

    // One clock: drive plan entry, feed delayed mins, advance the model.
    task automatic step();
        int idx;
        @(posedge clk);
        #1;
        if (cyc < plen && pv[cyc]) begin
            in_valid = 1'b1;
            for (int j = 0; j < 32; j++) set_din(j, px[cyc][j]);
        end else begin
            in_valid = 1'b0;
            for (int j = 0; j < 32; j++) set_din(j, rnd_x());
        end
        idx = cyc - ML;
        if (idx >= 0 && idx < plen && pv[idx]) begin
            min_add = LW'(pma[idx]);
            min_sub = LW'(pms[idx]);
        end else begin
            min_add = LW'($urandom);
            min_sub = LW'($urandom);
        end
        idx = cyc - ML - 1;
        if (idx >= 0 && idx < plen && pv[idx]) begin
            e_v = 1;
            e_l = (m_cnt == FB - 1);
            m_cnt = (m_cnt + 1) % FB;
            e_ea = clamp_s(pma[idx]);
            e_es = clamp_s(pms[idx]);
            for (int j = 0; j < 32; j++)
                e_d[j] = ref_scale(px[idx][j], (j < 16) ? pma[idx] : pms[idx]);
        end else begin
            e_v = 0;
            e_l = 0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        clear_plan();
    endtask

    task automatic test_reset();
        int bad;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int j = 0; j < 32; j++) if (got(j) != 0) bad++;
        checks++;
        if (bad != 0 || out_valid !== 1'b0 || out_last !== 1'b0
            || exp_add !== '0 || exp_sub !== '0) begin
            failures++;
            $display("FAIL reset_state nonzero_dout=%0d valid=%0b last=%0b",
                     bad, out_valid, out_last);
        end
        rstn = 1'b1;
        model_reset();
        clear_plan();
        repeat (6) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || got(0) != 0) begin
                failures++;
                $display("FAIL reset_idle valid=%0b dout0=%0d required 0/0",
                         out_valid, got(0));
            end
        end
    endtask

    task automatic test_single();
        int seen;
        int bad;
        clear_plan();
        add_beat(1, 10, 10, 256, 256, 0);
        seen = 0;
        repeat (plen + ML + 1) begin
            step();
            checks++;
            if (out_valid !== e_v) begin
                failures++;
                $display("FAIL single_valid cyc=%0d got=%0b required=%0b",
                         cyc, out_valid, e_v);
            end
            if (e_v) begin
                seen++;
                bad = 0;
                for (int j = 0; j < 32; j++) if (got(j) != 64) bad++;
                checks++;
                if (bad != 0 || exp_add !== 5'd10 || exp_sub !== 5'd10) begin
                    failures++;
                    $display("FAIL single_data bad=%0d dout0=%0d exp=%0d/%0d required 64 10/10",
                             bad, got(0), exp_add, exp_sub);
                end
            end
        end
        checks++;
        if (seen != 1 || cyc != ML + 2) begin
            failures++;
            $display("FAIL single_latency beats=%0d required 1", seen);
        end
    endtask

    task automatic test_round_sat();
        int xs [0:3];
        int ys [0:3];
        int k;
        int bad;
        xs = '{32'h3FFFFF, -4194304, 2048, -2048};
        ys = '{1023, -1024, 1, 0};
        clear_plan();
        for (int i = 0; i < 4; i++) add_beat(1, 0, 0, xs[i], xs[i], 0);
        k = 0;
        repeat (plen + ML + 1) begin
            step();
            if (e_v && k < 4) begin
                bad = 0;
                for (int j = 0; j < 32; j++) if (got(j) != ys[k]) bad++;
                checks++;
                if (bad != 0 || out_valid !== 1'b1 || exp_add !== '0) begin
                    failures++;
                    $display("FAIL round_sat x=%0d got=%0d required=%0d valid=%0b",
                             xs[k], got(0), ys[k], out_valid);
                end
                k++;
            end
        end
    endtask

    task automatic test_clamp();
        int bad;
        clear_plan();
        add_beat(1, 31, 0, 1, 4096, 0);
        repeat (plen + ML + 1) begin
            step();
            if (e_v) begin
                bad = 0;
                for (int j = 0; j < 16; j++) if (got(j) != 1023) bad++;
                for (int j = 16; j < 32; j++) if (got(j) != 1) bad++;
                checks++;
                if (bad != 0 || exp_add !== 5'd22 || exp_sub !== 5'd0) begin
                    failures++;
                    $display("FAIL clamp add=%0d sub=%0d exp=%0d/%0d required 1023 1 22/0",
                             got(0), got(16), exp_add, exp_sub);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int first;
        int last;
        int bad;
        apply_reset();
        for (int i = 0; i < FB + 2; i++)
            add_beat(1, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 1);
        n = 0;
        first = -1;
        last = -1;
        repeat (plen + ML + 1) begin
            step();
            if (out_valid === 1'b1) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
                checks++;
                if (out_last !== (n == FB)) begin
                    failures++;
                    $display("FAIL b2b_last beat=%0d got=%0b required=%0b",
                             n, out_last, (n == FB));
                end
                bad = 0;
                for (int j = 0; j < 32; j++) if (got(j) != e_d[j]) bad++;
                checks++;
                if (bad != 0 || int'(exp_add) != e_ea || int'(exp_sub) != e_es) begin
                    failures++;
                    $display("FAIL b2b_data beat=%0d bad=%0d dout0=%0d required=%0d",
                             n, bad, got(0), e_d[0]);
                end
            end
        end
        checks++;
        if (n != FB + 2 || last - first + 1 != FB + 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d span=%0d required=%0d",
                     n, last - first + 1, FB + 2);
        end
    endtask

    task automatic test_random_gaps();
        int bad;
        clear_plan();
        for (int i = 0; i < 40; i++)
            add_beat($urandom_range(0, 9) < 6, $urandom_range(0, 31),
                     $urandom_range(0, 31), 0, 0, 1);
        repeat (plen + ML + 1) begin
            step();
            checks++;
            if (out_valid !== e_v || out_last !== e_l) begin
                failures++;
                $display("FAIL gaps_ctrl cyc=%0d valid=%0b last=%0b required %0b/%0b",
                         cyc, out_valid, out_last, e_v, e_l);
            end
            bad = 0;
            for (int j = 0; j < 32; j++) if (got(j) != e_d[j]) bad++;
            checks++;
            if (bad != 0 || int'(exp_add) != e_ea || int'(exp_sub) != e_es) begin
                failures++;
                $display("FAIL gaps_data cyc=%0d bad=%0d exp=%0d/%0d required %0d/%0d",
                         cyc, bad, exp_add, exp_sub, e_ea, e_es);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int bad;
        int n;
        clear_plan();
        add_beat(1, 3, 4, 0, 0, 1);
        add_beat(1, 5, 6, 0, 0, 1);
        repeat (3) step();
        #1;
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        bad = 0;
        for (int j = 0; j < 32; j++) if (got(j) != 0) bad++;
        checks++;
        if (bad != 0 || out_valid !== 1'b0 || exp_add !== '0 || exp_sub !== '0) begin
            failures++;
            $display("FAIL midreset_async bad=%0d valid=%0b required 0/0",
                     bad, out_valid);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        clear_plan();
        repeat (6) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || got(0) != 0 || got(31) != 0) begin
                failures++;
                $display("FAIL midreset_ghost valid=%0b dout0=%0d required 0/0",
                         out_valid, got(0));
            end
        end
        clear_plan();
        for (int i = 0; i < FB; i++)
            add_beat(1, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 1);
        n = 0;
        repeat (plen + ML + 1) begin
            step();
            if (out_valid === 1'b1) begin
                n++;
                checks++;
                if (out_last !== (n == FB)) begin
                    failures++;
                    $display("FAIL midreset_last beat=%0d got=%0b required=%0b",
                             n, out_last, (n == FB));
                end
            end
        end
        checks++;
        if (n != FB) begin
            failures++;
            $display("FAIL midreset_count got=%0d required=%0d", n, FB);
        end
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        min_add = '0;
        min_sub = '0;
        for (int j = 0; j < 32; j++) set_din(j, 0);
        model_reset();
        clear_plan();
        test_reset();
        test_single();
        test_round_sat();
        test_clamp();
        test_back_to_back();
        test_random_gaps();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
